// File: rtl/sram_dump_tx.sv
// Streams a block of 16-bit SRAM words out of an 8N1 UART, low byte first.
// SRAM is read through a req/valid port owned by another block.
module sram_dump_tx #(
   parameter int unsigned CLK_FREQ = 100000000,
   parameter int unsigned ADDR_W   = 19,
   parameter int unsigned BAUD0    = 9600,
   parameter int unsigned BAUD1    = 19200,
   parameter int unsigned BAUD2    = 57600,
   parameter int unsigned BAUD3    = 115200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_count,
   input  logic [1:0]        brate_selection,
   output logic              sram_req,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [15:0]       sram_rdata,
   input  logic              sram_valid,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int unsigned DIV0 = CLK_FREQ / BAUD0;
   localparam int unsigned DIV1 = CLK_FREQ / BAUD1;
   localparam int unsigned DIV2 = CLK_FREQ / BAUD2;
   localparam int unsigned DIV3 = CLK_FREQ / BAUD3;
   localparam int unsigned DIV_A   = (DIV0 > DIV1) ? DIV0 : DIV1;
   localparam int unsigned DIV_B   = (DIV2 > DIV3) ? DIV2 : DIV3;
   localparam int unsigned DIV_MAX = (DIV_A > DIV_B) ? DIV_A : DIV_B;
   localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);

   typedef enum logic [2:0] {StIdle, StFetch, StSendLo, StSendHi, StFin} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] remain_q, remain_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        bit_q, bit_d;
   logic [15:0]       data_q, data_d;
   logic              tx_q, tx_d;

   logic [DIV_W-1:0]  sel_div;
   logic [7:0]        cur_byte;
   logic              bit_end;
   logic [ADDR_W-1:0] remain_dec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         remain_q <= '0;
         div_q    <= '0;
         cnt_q    <= '0;
         bit_q    <= '0;
         data_q   <= '0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         data_q   <= data_d;
         tx_q     <= tx_d;
      end
   end

   always_comb begin
      sel_div = DIV_W'(DIV0);
      unique case (brate_selection)
         2'b00: sel_div = DIV_W'(DIV0);
         2'b01: sel_div = DIV_W'(DIV1);
         2'b10: sel_div = DIV_W'(DIV2);
         2'b11: sel_div = DIV_W'(DIV3);
         default: sel_div = DIV_W'(DIV0);
      endcase
   end

   assign cur_byte   = (state_q == StSendHi) ? data_q[15:8] : data_q[7:0];
   assign bit_end    = (cnt_q == div_q - DIV_W'(1));
   assign remain_dec = remain_q - ADDR_W'(1);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      data_d   = data_q;
      tx_d     = tx_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               addr_d   = base_addr;
               remain_d = word_count;
               div_d    = sel_div;
               cnt_d    = '0;
               bit_d    = '0;
               state_d  = (word_count == '0) ? StFin : StFetch;
            end
         end
         StFetch: begin
            if (sram_valid) begin
               data_d  = sram_rdata;
               tx_d    = 1'b0;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = StSendLo;
            end
         end
         StSendLo, StSendHi: begin
            if (!bit_end) begin
               cnt_d = cnt_q + DIV_W'(1);
            end else begin
               cnt_d = '0;
               if (bit_q == 4'd9) begin
                  // Stop bit finished: chain straight into the next frame or fetch.
                  bit_d = '0;
                  if (state_q == StSendLo) begin
                     tx_d    = 1'b0;
                     state_d = StSendHi;
                  end else begin
                     tx_d     = 1'b1;
                     remain_d = remain_dec;
                     addr_d   = addr_q + ADDR_W'(1);
                     state_d  = (remain_dec == '0) ? StFin : StFetch;
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
                  tx_d  = (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign sram_req  = (state_q == StFetch);
   assign sram_addr = addr_q;
   assign tx        = tx_q;
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StFin);

endmodule

// File: tb/tb_sram_dump_tx.sv
// Randomized self-checking bench for sram_dump_tx; a reduced clock frequency keeps
// every bit period short while preserving the truncating divisor rule.
module tb_sram_dump_tx;

   localparam int unsigned CLK_FREQ = 1000000;
   localparam int unsigned ADDR_W   = 19;

   logic              clk = 1'b0;
   logic              clk_en = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] word_count = '0;
   logic [1:0]        brate_selection = 2'b00;
   logic              sram_req;
   logic [ADDR_W-1:0] sram_addr;
   logic [15:0]       sram_rdata = '0;
   logic              sram_valid = 1'b0;
   logic              tx;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;

   sram_dump_tx #(
      .CLK_FREQ(CLK_FREQ),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .base_addr      (base_addr),
      .word_count     (word_count),
      .brate_selection(brate_selection),
      .sram_req       (sram_req),
      .sram_addr      (sram_addr),
      .sram_rdata     (sram_rdata),
      .sram_valid     (sram_valid),
      .tx             (tx),
      .busy           (busy),
      .done           (done)
   );

   always #5 if (clk_en) clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Bit period from the baud rules: truncating CLK_FREQ / baud.
   function automatic int exp_div(input logic [1:0] sel);
      case (sel)
         2'b00:   return CLK_FREQ / 9600;
         2'b01:   return CLK_FREQ / 19200;
         2'b10:   return CLK_FREQ / 57600;
         default: return CLK_FREQ / 115200;
      endcase
   endfunction

   // Observes one 10-bit frame starting at the current negedge; optionally pokes
   // brate_selection and a start pulse at sample index poke_at.
   task automatic rx_byte(input int div, input logic [7:0] exp, input int poke_at,
                          input string tag);
      logic [9:0] bits;
      int         glitches;
      logic       first;
      glitches = 0;
      bits = '0;
      for (int b = 0; b < 10; b++) begin
         first = tx;
         for (int c = 0; c < div; c++) begin
            if (tx !== first) glitches++;
            start = 1'b0;
            if (poke_at >= 0 && b * div + c == poke_at) begin
               brate_selection = ~brate_selection;
               start = 1'b1;
            end
            @(negedge clk);
         end
         bits[b] = first;
      end
      start = 1'b0;
      check_eq({tag, "_startbit"}, 32'(bits[0]), 32'd0);
      check_eq({tag, "_data"}, 32'(bits[8:1]), 32'(exp));
      check_eq({tag, "_stopbit"}, 32'(bits[9]), 32'd1);
      check_eq({tag, "_bitlen"}, 32'(glitches), 32'd0);
   endtask

   task automatic dump(input logic [ADDR_W-1:0] base, input int count, input logic [1:0] sel,
                       input int lat_min, input int lat_max, input int poke_at);
      int                div;
      int                lat;
      logic [ADDR_W-1:0] a;
      logic [15:0]       w;
      div = exp_div(sel);
      @(negedge clk);
      base_addr = base;
      word_count = ADDR_W'(count);
      brate_selection = sel;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("busy_after_start", 32'(busy), 32'd1);
      if (count == 0) begin
         check_eq("zero_done", 32'(done), 32'd1);
         check_eq("zero_req", 32'(sram_req), 32'd0);
         check_eq("zero_tx", 32'(tx), 32'd1);
         start = 1'b1;  // start in the done cycle must be dropped
         @(negedge clk);
         start = 1'b0;
         check_eq("zero_busy_end", 32'(busy), 32'd0);
         check_eq("zero_done_end", 32'(done), 32'd0);
         @(negedge clk);
         check_eq("zero_no_restart", 32'(busy), 32'd0);
         return;
      end
      for (int i = 0; i < count; i++) begin
         a = base + ADDR_W'(i);
         lat = $urandom_range(lat_max, lat_min);
         check_eq("fetch_done_low", 32'(done), 32'd0);
         for (int l = 0; l <= lat; l++) begin
            check_eq("fetch_req", 32'(sram_req), 32'd1);
            check_eq("fetch_addr", 32'(sram_addr), 32'(a));
            check_eq("fetch_tx_idle", 32'(tx), 32'd1);
            if (l < lat) @(negedge clk);
         end
         w = 16'($urandom);
         sram_rdata = w;
         sram_valid = 1'b1;
         @(negedge clk);
         sram_valid = 1'b0;
         sram_rdata = 16'($urandom);
         check_eq("req_dropped", 32'(sram_req), 32'd0);
         rx_byte(div, w[7:0], (i == 0) ? poke_at : -1, "lo");
         rx_byte(div, w[15:8], -1, "hi");
      end
      check_eq("done_pulse", 32'(done), 32'd1);
      check_eq("done_req", 32'(sram_req), 32'd0);
      check_eq("done_tx", 32'(tx), 32'd1);
      @(negedge clk);
      check_eq("done_single", 32'(done), 32'd0);
      check_eq("busy_cleared", 32'(busy), 32'd0);
   endtask

   initial begin
      // Reset with the clock stopped.
      #1 rst = 1'b1;
      #2;
      check_eq("rst_tx", 32'(tx), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_req", 32'(sram_req), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_addr", 32'(sram_addr), 32'd0);
      clk_en = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Stray completion strobe with no request outstanding.
      sram_valid = 1'b1;
      @(negedge clk);
      sram_valid = 1'b0;
      @(negedge clk);
      check_eq("stray_valid_busy", 32'(busy), 32'd0);
      check_eq("stray_valid_tx", 32'(tx), 32'd1);

      dump(19'h00010, 1, 2'b11, 3, 3, -1);
      dump(19'h00123, 0, 2'b11, 0, 0, -1);
      dump(19'h7FFFF, 2, 2'b10, 0, 4, -1);
      // Baud and start changes mid-byte must not disturb the running dump.
      dump(19'h00400, 1, 2'b00, 1, 3, 3 * exp_div(2'b00) + 7);

      // Asynchronous reset in the middle of data bit 4 of the first byte.
      begin
         int div;
         div = exp_div(2'b11);
         @(negedge clk);
         base_addr = 19'h00005;
         word_count = 19'd1;
         brate_selection = 2'b11;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (2) @(negedge clk);
         sram_rdata = 16'h002B;
         sram_valid = 1'b1;
         @(negedge clk);
         sram_valid = 1'b0;
         repeat (5 * div + div / 2) @(negedge clk);
         check_eq("pre_abort_tx", 32'(tx), 32'd0);
         #2 rst = 1'b1;
         #1;
         check_eq("abort_tx", 32'(tx), 32'd1);
         check_eq("abort_busy", 32'(busy), 32'd0);
         check_eq("abort_req", 32'(sram_req), 32'd0);
         @(negedge clk);
         rst = 1'b0;
         repeat (2) @(negedge clk);
         check_eq("post_abort_tx", 32'(tx), 32'd1);
      end
      dump(19'h00020, 1, 2'b11, 0, 3, -1);

      for (int n = 0; n < 6; n++) begin
         logic [ADDR_W-1:0] b;
         b = ($urandom_range(2, 0) == 0) ? (19'h7FFFF - ADDR_W'($urandom_range(1, 0)))
                                        : ADDR_W'($urandom);
         dump(b, $urandom_range(3, 1), 2'($urandom_range(3, 1)), 0, 6, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
